// File: rtl/pipe_sequencer_if.sv
// Pipeline control bundle between the sequencer and the 5-stage datapath.
// The master side (sequencer) consumes hazard/jump/memory requests.
// It drives the per-stage stall and flush controls.
interface pipe_sequencer_if;
  logic hazard_rd;
  logic jumping;
  logic mem_req;
  logic mem_ack;
  logic stall_F;
  logic stall_D;
  logic stall_E;
  logic stall_M;
  logic stall_WB;
  logic flush_D;
  logic flush_E;
  logic flush_M;
  logic flush_WB;
  logic mem_err;

  modport master (
    input  hazard_rd, jumping, mem_req, mem_ack,
    output stall_F, stall_D, stall_E, stall_M, stall_WB,
    output flush_D, flush_E, flush_M, flush_WB, mem_err
  );

  modport slave (
    output hazard_rd, jumping, mem_req, mem_ack,
    input  stall_F, stall_D, stall_E, stall_M, stall_WB,
    input  flush_D, flush_E, flush_M, flush_WB, mem_err
  );
endinterface

// File: rtl/pipe_sequencer.sv
// Central stall/flush controller for the F/D/E/M/WB pipeline.
// Priority is memory wait over jump over decode hazard. A jump opens a
// multi-cycle flush window. A memory miss parks the pipe in MEM_WAIT,
// with an optional timeout abort. Two saturating counters track stall and
// flush activity.
module pipe_sequencer #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned CNT_W        = 32
) (
  input  logic               clk,
  input  logic               reset,
  pipe_sequencer_if.master   ctl,
  input  logic               perf_clr,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   stall_count,
  output logic [CNT_W-1:0]   flush_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_REDIRECT = 2'b01,
    ST_MEM_WAIT = 2'b10
  } state_e;

  localparam logic [3:0]  FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [15:0] TIMEOUT    = 16'(MEM_TIMEOUT);

  state_e             state_q, state_d;
  logic [3:0]         fcnt_q, fcnt_d;
  logic [15:0]        wait_cnt_q, wait_cnt_d;
  logic               ret_redirect_q, ret_redirect_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;
  logic [CNT_W-1:0]   flush_count_q, flush_count_d;

  logic stall_fdem;
  logic stall_fd;
  logic flush_d, flush_e, flush_m, flush_wb;
  logic mem_err;
  logic mem_miss;
  logic stall_any, flush_any;

  assign mem_miss = ctl.mem_req & ~ctl.mem_ack;

  // Next-state and raw control decode; memory beats jump beats hazard
  always_comb begin
    state_d        = state_q;
    fcnt_d         = fcnt_q;
    wait_cnt_d     = wait_cnt_q;
    ret_redirect_d = ret_redirect_q;
    stall_fdem     = 1'b0;
    stall_fd       = 1'b0;
    flush_d        = 1'b0;
    flush_e        = 1'b0;
    flush_m        = 1'b0;
    flush_wb       = 1'b0;
    mem_err        = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_miss) begin
          stall_fdem     = 1'b1;
          flush_wb       = 1'b1;
          state_d        = ST_MEM_WAIT;
          ret_redirect_d = 1'b0;
          wait_cnt_d     = 16'd1;
        end else if (ctl.jumping) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_REDIRECT;
            fcnt_d  = FLUSH_INIT;
          end
        end else if (ctl.hazard_rd) begin
          stall_fd = 1'b1;
          flush_e  = 1'b1;
        end
      end
      ST_REDIRECT: begin
        if (mem_miss) begin
          stall_fdem     = 1'b1;
          flush_wb       = 1'b1;
          state_d        = ST_MEM_WAIT;
          ret_redirect_d = 1'b1;
          wait_cnt_d     = 16'd1;
        end else begin
          flush_d = 1'b1;
          flush_e = 1'b1;
          fcnt_d  = fcnt_q - 4'd1;
          if (fcnt_q <= 4'd1) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (ctl.mem_ack) begin
          state_d        = ret_redirect_q ? ST_REDIRECT : ST_RUN;
          ret_redirect_d = 1'b0;
        end else if ((TIMEOUT != 16'd0) && (wait_cnt_q == TIMEOUT)) begin
          mem_err        = 1'b1;
          flush_m        = 1'b1;
          state_d        = ST_RUN;
          ret_redirect_d = 1'b0;
        end else begin
          stall_fdem = 1'b1;
          flush_wb   = 1'b1;
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Drive the stage controls, forced quiet while reset is held low
  always_comb begin
    ctl.stall_F  = reset & (stall_fdem | stall_fd);
    ctl.stall_D  = reset & (stall_fdem | stall_fd);
    ctl.stall_E  = reset & stall_fdem;
    ctl.stall_M  = reset & stall_fdem;
    ctl.stall_WB = 1'b0;
    ctl.flush_D  = reset & flush_d;
    ctl.flush_E  = reset & flush_e;
    ctl.flush_M  = reset & flush_m;
    ctl.flush_WB = reset & flush_wb;
    ctl.mem_err  = reset & mem_err;
  end

  assign stall_any = ctl.stall_F | ctl.stall_D | ctl.stall_E | ctl.stall_M | ctl.stall_WB;
  assign flush_any = ctl.flush_D | ctl.flush_E | ctl.flush_M | ctl.flush_WB;

  // Saturating perf counters; a clear request wins over counting
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (perf_clr) begin
      stall_count_d = '0;
      flush_count_d = '0;
    end else begin
      if (stall_any && !(&stall_count_q)) begin
        stall_count_d = stall_count_q + CNT_W'(1);
      end
      if (flush_any && !(&flush_count_q)) begin
        flush_count_d = flush_count_q + CNT_W'(1);
      end
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_RUN;
      fcnt_q         <= 4'd0;
      wait_cnt_q     <= 16'd0;
      ret_redirect_q <= 1'b0;
      stall_count_q  <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      fcnt_q         <= fcnt_d;
      wait_cnt_q     <= wait_cnt_d;
      ret_redirect_q <= ret_redirect_d;
      stall_count_q  <= stall_count_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign state       = state_q;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Bench for pipe_sequencer with FLUSH_CYCLES=2, MEM_TIMEOUT=8, CNT_W=4.
// Table vectors carry hand-derived expectations. They go through a
// scoreboard queue and are checked half a cycle after being driven.
module tb_pipe_sequencer;

  logic       clk;
  logic       reset;
  logic       perf_clr;
  logic [1:0] state;
  logic [3:0] stall_count;
  logic [3:0] flush_count;

  pipe_sequencer_if bus ();

  pipe_sequencer #(
    .FLUSH_CYCLES (2),
    .MEM_TIMEOUT  (8),
    .CNT_W        (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ctl         (bus),
    .perf_clr    (perf_clr),
    .state       (state),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );

  typedef struct packed {
    logic [4:0] stall;   // {F,D,E,M,WB}
    logic [3:0] flush;   // {D,E,M,WB}
    logic       err;
    logic [1:0] st;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  typedef struct {
    logic hz;
    logic jmp;
    logic req;
    logic ack;
    logic clr;
    exp_t e;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_compared;
  int   n_mismatched;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic hz, jmp, req, ack, clr,
                     input logic [4:0] stl, input logic [3:0] fl,
                     input logic err, input logic [1:0] st, input int sc, input int fc);
    vec_t v;
    v.hz = hz; v.jmp = jmp; v.req = req; v.ack = ack; v.clr = clr;
    v.e.stall = stl; v.e.flush = fl; v.e.err = err; v.e.st = st;
    v.e.sc = 4'(sc); v.e.fc = 4'(fc);
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.hazard_rd = v.hz;
    bus.jumping   = v.jmp;
    bus.mem_req   = v.req;
    bus.mem_ack   = v.ack;
    perf_clr      = v.clr;
    sb.push_back(v.e);
  endtask

  task automatic checkOutput(input string name);
    exp_t act;
    exp_t e;
    act.stall = {bus.stall_F, bus.stall_D, bus.stall_E, bus.stall_M, bus.stall_WB};
    act.flush = {bus.flush_D, bus.flush_E, bus.flush_M, bus.flush_WB};
    act.err   = bus.mem_err;
    act.st    = state;
    act.sc    = stall_count;
    act.fc    = flush_count;
    n_compared++;
    if (sb.size() == 0) begin
      n_mismatched++;
      $display("[TB] FAIL %s: scoreboard empty, got stall=%b flush=%b", name, act.stall, act.flush);
    end else begin
      e = sb.pop_front();
      if (act !== e) begin
        n_mismatched++;
        $display("[TB] FAIL %s: got stall=%b flush=%b err=%b st=%b sc=%0d fc=%0d, need stall=%b flush=%b err=%b st=%b sc=%0d fc=%0d",
                 name, act.stall, act.flush, act.err, act.st, act.sc, act.fc,
                 e.stall, e.flush, e.err, e.st, e.sc, e.fc);
      end
    end
  endtask

  function automatic vec_t mk(input logic hz, jmp, req, ack, input int sc, fc, input logic [1:0] st,
                              input logic [4:0] stl, input logic [3:0] fl);
    vec_t v;
    v.hz = hz; v.jmp = jmp; v.req = req; v.ack = ack; v.clr = 1'b0;
    v.e.stall = stl; v.e.flush = fl; v.e.err = 1'b0; v.e.st = st;
    v.e.sc = 4'(sc); v.e.fc = 4'(fc);
    return v;
  endfunction

  initial begin
    n_compared   = 0;
    n_mismatched = 0;

    //  hz jmp req ack clr  stall     flush    err st     sc fc
    // hazard for three cycles
    add(1, 0, 0, 0, 0, 5'b11000, 4'b0100, 0, 2'b00, 0, 0);
    add(1, 0, 0, 0, 0, 5'b11000, 4'b0100, 0, 2'b00, 1, 1);
    add(1, 0, 0, 0, 0, 5'b11000, 4'b0100, 0, 2'b00, 2, 2);
    add(0, 0, 0, 0, 0, 5'b00000, 4'b0000, 0, 2'b00, 3, 3);
    add(0, 0, 0, 0, 1, 5'b00000, 4'b0000, 0, 2'b00, 3, 3);
    // one-cycle jump, hazard ignored inside the redirect window
    add(0, 1, 0, 0, 0, 5'b00000, 4'b1100, 0, 2'b00, 0, 0);
    add(1, 0, 0, 0, 0, 5'b00000, 4'b1100, 0, 2'b01, 0, 1);
    add(0, 0, 0, 0, 0, 5'b00000, 4'b0000, 0, 2'b00, 0, 2);
    // memory miss acked on the fifth cycle
    add(0, 0, 1, 0, 0, 5'b11110, 4'b0001, 0, 2'b00, 0, 2);
    add(0, 0, 1, 0, 0, 5'b11110, 4'b0001, 0, 2'b10, 1, 3);
    add(0, 0, 1, 0, 0, 5'b11110, 4'b0001, 0, 2'b10, 2, 4);
    add(0, 0, 1, 0, 0, 5'b11110, 4'b0001, 0, 2'b10, 3, 5);
    add(0, 0, 1, 1, 0, 5'b00000, 4'b0000, 0, 2'b10, 4, 6);
    add(0, 0, 0, 0, 0, 5'b00000, 4'b0000, 0, 2'b00, 4, 6);
    add(0, 0, 0, 0, 1, 5'b00000, 4'b0000, 0, 2'b00, 4, 6);
    // single-cycle access lets the hazard through
    add(1, 0, 1, 1, 0, 5'b11000, 4'b0100, 0, 2'b00, 0, 0);
    add(0, 0, 0, 0, 0, 5'b00000, 4'b0000, 0, 2'b00, 1, 1);
    // timeout after 8 wait cycles
    add(0, 0, 1, 0, 0, 5'b11110, 4'b0001, 0, 2'b00, 1, 1);
    for (int i = 0; i < 7; i++)
      add(0, 0, 1, 0, 0, 5'b11110, 4'b0001, 0, 2'b10, 2 + i, 2 + i);
    add(0, 0, 1, 0, 0, 5'b00000, 4'b0010, 1, 2'b10, 9, 9);
    add(0, 0, 0, 0, 0, 5'b00000, 4'b0000, 0, 2'b00, 9, 10);
    // ack on the timeout cycle wins; counters saturate at 15 on the way
    add(0, 0, 1, 0, 0, 5'b11110, 4'b0001, 0, 2'b00, 9, 10);
    add(0, 0, 1, 0, 0, 5'b11110, 4'b0001, 0, 2'b10, 10, 11);
    add(0, 0, 1, 0, 0, 5'b11110, 4'b0001, 0, 2'b10, 11, 12);
    add(0, 0, 1, 0, 0, 5'b11110, 4'b0001, 0, 2'b10, 12, 13);
    add(0, 0, 1, 0, 0, 5'b11110, 4'b0001, 0, 2'b10, 13, 14);
    add(0, 0, 1, 0, 0, 5'b11110, 4'b0001, 0, 2'b10, 14, 15);
    add(0, 0, 1, 0, 0, 5'b11110, 4'b0001, 0, 2'b10, 15, 15);
    add(0, 0, 1, 0, 0, 5'b11110, 4'b0001, 0, 2'b10, 15, 15);
    add(0, 0, 1, 1, 0, 5'b00000, 4'b0000, 0, 2'b10, 15, 15);
    add(0, 0, 0, 0, 0, 5'b00000, 4'b0000, 0, 2'b00, 15, 15);
    add(0, 0, 0, 0, 1, 5'b00000, 4'b0000, 0, 2'b00, 15, 15);
    // miss inside the redirect window, then resume the last flush cycle
    add(0, 1, 0, 0, 0, 5'b00000, 4'b1100, 0, 2'b00, 0, 0);
    add(0, 0, 1, 0, 0, 5'b11110, 4'b0001, 0, 2'b01, 0, 1);
    add(0, 0, 1, 0, 0, 5'b11110, 4'b0001, 0, 2'b10, 1, 2);
    add(0, 0, 1, 0, 0, 5'b11110, 4'b0001, 0, 2'b10, 2, 3);
    add(0, 0, 1, 1, 0, 5'b00000, 4'b0000, 0, 2'b10, 3, 4);
    add(0, 0, 0, 0, 0, 5'b00000, 4'b1100, 0, 2'b01, 3, 4);
    add(0, 0, 0, 0, 0, 5'b00000, 4'b0000, 0, 2'b00, 3, 5);
    // jump and hazard ignored while redirecting
    add(0, 1, 0, 0, 0, 5'b00000, 4'b1100, 0, 2'b00, 3, 5);
    add(1, 1, 0, 0, 0, 5'b00000, 4'b1100, 0, 2'b01, 3, 6);
    add(0, 0, 0, 0, 0, 5'b00000, 4'b0000, 0, 2'b00, 3, 7);
    // memory miss outranks a jump
    add(0, 1, 1, 0, 0, 5'b11110, 4'b0001, 0, 2'b00, 3, 7);
    add(0, 1, 1, 1, 0, 5'b00000, 4'b0000, 0, 2'b10, 4, 8);
    add(0, 0, 0, 0, 1, 5'b00000, 4'b0000, 0, 2'b00, 4, 8);

    // reset state, with every request active to show outputs are forced low
    reset         = 1'b0;
    bus.hazard_rd = 1'b0;
    bus.jumping   = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_ack   = 1'b0;
    perf_clr      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(mk(1, 1, 1, 0, 0, 0, 2'b00, 5'b00000, 4'b0000));
    @(negedge clk);
    checkOutput("reset_state");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 2'b00, 5'b00000, 4'b0000));
    void'(sb.pop_back());
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i));
    end

    // reset in the middle of a memory wait
    @(posedge clk); #1;
    applyStimulus(mk(0, 0, 1, 0, 0, 0, 2'b00, 5'b11110, 4'b0001));
    @(negedge clk); checkOutput("mw_enter");
    @(posedge clk); #1;
    applyStimulus(mk(0, 0, 1, 0, 1, 1, 2'b10, 5'b11110, 4'b0001));
    @(negedge clk); checkOutput("mw_waiting");
    #2;
    reset = 1'b0;
    applyStimulus(mk(1, 1, 1, 0, 0, 0, 2'b00, 5'b00000, 4'b0000));
    #1; checkOutput("mw_reset_now");
    @(negedge clk);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 2'b00, 5'b00000, 4'b0000));
    void'(sb.pop_back());
    reset = 1'b1;
    @(posedge clk); #1;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 2'b00, 5'b00000, 4'b0000));
    @(negedge clk); checkOutput("mw_after_reset");

    // reset in the middle of a redirect window
    @(posedge clk); #1;
    applyStimulus(mk(0, 1, 0, 0, 0, 0, 2'b00, 5'b00000, 4'b1100));
    @(negedge clk); checkOutput("rd_jump");
    @(posedge clk); #1;
    applyStimulus(mk(0, 0, 0, 0, 0, 1, 2'b01, 5'b00000, 4'b1100));
    @(negedge clk); checkOutput("rd_window");
    #2;
    reset = 1'b0;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 2'b00, 5'b00000, 4'b0000));
    #1; checkOutput("rd_reset_now");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 2'b00, 5'b00000, 4'b0000));
    @(negedge clk); checkOutput("rd_after_reset");

    if (sb.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d leftover, need 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Hard stop in case the stimulus process never completes
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, need completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
